// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state type shared by the UART receiver and transmitter
package uart_pkg;
  localparam int BAUD_DIV_DEFAULT = 868;
  localparam int DATA_BITS = 8;
  localparam int BAUD_CNT_W = 14;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running counter that ticks on its terminal count and wraps to zero
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int TERM_COUNT = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);
  logic [BAUD_CNT_W-1:0] r_cnt;
  assign o_tick = i_enable && (r_cnt == BAUD_CNT_W'(TERM_COUNT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clear || o_tick) r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with mid-bit sampling, one-deep holding register and per-byte error flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIVISOR = BAUD_DIV_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_en,
  input  logic                 Two_stop,
  input  logic                 Odd_parity,
  input  logic                 Rx_in,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic [2:0] r_bit_cnt;
  logic r_rxs_d, r_two, r_odd, r_par_err, r_frm_err;
  logic r_valid, r_perr, r_ferr, r_ovr;
  logic w_rxs, w_half_tick, w_full_tick, w_full_clr, w_done, w_load, w_ferr;
  assign w_rxs = r_sync[SYNC_STAGES-1];
  assign w_full_clr = (r_state == IDLE) || (r_state == START);
  assign w_done = Rx_en && w_full_tick && (r_state == STOP2 || (r_state == STOP1 && !r_two));
  assign w_load = w_done && (!r_valid || rd_en);
  assign w_ferr = !w_rxs || (r_state == STOP2 && r_frm_err);
  assign rx_data = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err = r_ferr;
  assign overrun_err = r_ovr;
  uart_baud_gen #(.TERM_COUNT(BAUD_DIVISOR / 2)) u_half (
    .clk(clk), .rst(rst), .i_clear(r_state != START), .i_enable(r_state == START), .o_tick(w_half_tick)
  );
  uart_baud_gen #(.TERM_COUNT(BAUD_DIVISOR)) u_full (
    .clk(clk), .rst(rst), .i_clear(w_full_clr), .i_enable(!w_full_clr), .o_tick(w_full_tick)
  );
  always_comb begin
    w_next = r_state;
    if (!Rx_en) w_next = IDLE;
    else
      case (r_state)
        IDLE:    if (r_rxs_d && !w_rxs) w_next = START;
        START:   if (w_half_tick) w_next = w_rxs ? IDLE : DATA;
        DATA:    if (w_full_tick && r_bit_cnt == 3'd7) w_next = PARITY;
        PARITY:  if (w_full_tick) w_next = STOP1;
        STOP1:   if (w_full_tick) w_next = r_two ? STOP2 : IDLE;
        STOP2:   if (w_full_tick) w_next = IDLE;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= '1;
      r_rxs_d <= 1'b1;
      r_state <= IDLE;
      r_shift <= '0;
      r_bit_cnt <= '0;
      r_two <= 1'b0;
      r_odd <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Rx_in};
      r_rxs_d <= w_rxs;
      r_state <= w_next;
      // frame options track the inputs while idle and freeze once a start edge is seen
      if (r_state == IDLE) begin
        r_two <= Two_stop;
        r_odd <= Odd_parity;
      end
      if (r_state != DATA) r_bit_cnt <= '0;
      else if (w_full_tick) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      end
      if (r_state == PARITY && w_full_tick) r_par_err <= (^r_shift ^ w_rxs) != r_odd;
      if (r_state == STOP1 && w_full_tick) r_frm_err <= !w_rxs;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_data <= '0;
      r_valid <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (rd_en && r_valid) begin
        r_valid <= 1'b0;
        r_ovr <= 1'b0;
      end
      if (w_done && r_valid && !rd_en) r_ovr <= 1'b1;
      if (w_load) begin
        r_data <= r_shift;
        r_perr <= r_par_err;
        r_ferr <= w_ferr;
        r_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level model of the receiver's holding register
module tb_uart_rx;
  localparam int D = 16;
  localparam int S = 2;
  logic clk = 1'b0, rst = 1'b1, Rx_en = 1'b0, Two_stop = 1'b0, Odd_parity = 1'b0, Rx_in = 1'b1, rd_en = 1'b0;
  logic [7:0] rx_data;
  logic data_valid, parity_err, frame_err, overrun_err;
  int checks = 0, errors = 0, cyc = 0, t_rise = -1;
  logic prev_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  uart_rx #(.BAUD_DIVISOR(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .Rx_en(Rx_en), .Two_stop(Two_stop), .Odd_parity(Odd_parity),
    .Rx_in(Rx_in), .rd_en(rd_en), .rx_data(rx_data), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid && !prev_valid) t_rise = cyc;
    prev_valid = data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"}, 32'(rx_data), 32'(m_data));
    chk({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
    chk({tag, ".perr"}, 32'(parity_err), 32'(m_perr));
    chk({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, ".ovr"}, 32'(overrun_err), 32'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end
    @(negedge clk);
  endtask

  // Drives one frame; rd_at/en_off_at/rst_at are cycle offsets from the start bit (-1 = unused)
  task automatic send(input logic [7:0] d, input logic p, input logic odd, input logic two,
                      input logic [1:0] stops, input int rd_at, input int en_off_at,
                      input int rst_at, input string tag);
    logic [11:0] bits;
    int n, t0, lat_exp;
    logic done, rd_c;
    bits = {stops, p, d, 1'b0};
    n = (two ? 12 : 11) * D;
    lat_exp = D / 2 + (two ? 11 : 10) * D + 1 + S;
    Odd_parity = odd;
    Two_stop = two;
    done = 1'b1;
    rd_c = 1'b0;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      Rx_in = bits[i / D];
      rd_en = (i == rd_at);
      if (i == rd_at) begin
        if (i == lat_exp - 1) rd_c = 1'b1;
        else if (m_valid) begin
          m_valid = 1'b0;
          m_ovr = 1'b0;
        end
      end
      if (i == en_off_at) begin
        Rx_en = 1'b0;
        done = 1'b0;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        done = 1'b0;
        #1;
        {m_data, m_valid, m_perr, m_ferr, m_ovr} = '0;
        check_all({tag, ".rst"});
      end
      @(negedge clk);
    end
    rd_en = 1'b0;
    Rx_in = 1'b1;
    if (done) begin
      if (!m_valid) chk({tag, ".lat"}, t_rise - t0, lat_exp);
      if (!m_valid || rd_c) begin
        m_data = d;
        m_perr = ((($countones(d) + int'(p)) % 2) == 1) != odd;
        m_ferr = !stops[0] || (two && !stops[1]);
        m_valid = 1'b1;
        m_ovr = 1'b0;
      end else m_ovr = 1'b1;
    end
    check_all(tag);
  endtask

  initial begin
    idle(3);
    check_all("reset");
    rst = 1'b0;
    Rx_en = 1'b1;
    idle(5);
    send(8'hA5, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1, -1, "clean");
    do_read();
    check_all("read_clean");
    send(8'h3C, 1'b0, 1'b1, 1'b1, 2'b11, -1, -1, -1, "odd2stop");
    do_read();
    Rx_in = 1'b0;
    idle(4);
    Rx_in = 1'b1;
    idle(3 * D);
    check_all("glitch");
    send(8'h55, 1'b0, 1'b0, 1'b0, 2'b10, -1, -1, -1, "badstop");
    idle(D);
    do_read();
    send(8'h11, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1, -1, "ovr_a");
    idle(4);
    send(8'h22, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1, -1, "ovr_b");
    do_read();
    check_all("ovr_read");
    send(8'h11, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1, -1, "rdc_a");
    idle(4);
    send(8'h22, 1'b0, 1'b0, 1'b0, 2'b11, D / 2 + 10 * D + S, -1, -1, "rdc_b");
    do_read();
    send(8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1, -1, "b2b_a");
    send(8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 20, -1, -1, "b2b_b");
    do_read();
    send(8'h5A, 1'b0, 1'b0, 1'b0, 2'b11, -1, 60, -1, "abort_en");
    idle(4);
    Rx_en = 1'b1;
    idle(2 * D);
    check_all("abort_en_idle");
    send(8'h77, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1, -1, "hold");
    idle(4);
    send(8'h99, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1, 80, "abort_rst");
    idle(3);
    rst = 1'b0;
    idle(3);
    send(8'h6B, 1'b1, 1'b0, 1'b0, 2'b11, -1, -1, -1, "post_rst");
    for (int k = 0; k < 12; k++) begin
      logic [1:0] st;
      st[0] = ($urandom_range(0, 4) != 0);
      st[1] = ($urandom_range(0, 4) != 0);
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), st, -1, -1, -1, $sformatf("rnd%0d", k));
      idle(2 * D);
      if ($urandom_range(0, 1) == 1) do_read();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
